// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the multiply/divide unit.
// Contents: XLEN, RV32M funct3 encodings and the muldiv FSM state type.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // funct3[2] separates divide/remainder from multiply.
  function automatic logic is_div_op(input logic [2:0] f);
    return f[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Two's-complement conditional negation. Used on the way in to turn signed
// operands into magnitudes and on the way out to restore the result sign.
// Ports:
//   value  - input word
//   negate - 1: result = -value, 0: result = value
//   result - output word
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes, sign restored at completion).
// Optional build macro: MULDIV_EARLY_OUT_EN - multiplies finish as soon as the
// remaining multiplier bits are all zero.
// Ports:
//   clk, rst (sync, active-low), flush (abort current op)
//   in_valid/in_ready, funct3, rs1_data, rs2_data, rd_addr - request
//   out_valid/out_ready, out_data, out_rd_addr             - writeback
//
// state   | meaning
// MD_IDLE | ready for a request
// MD_CALC | one multiply/divide iteration per cycle
// MD_DONE | result held until out_ready
module muldiv_unit #(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd_addr
);
  import rv32_pkg::*;

  localparam int CW = $clog2(XLEN + 1);

  md_state_t         state, state_next;
  logic [2*XLEN-1:0] acc, mcand, acc_next, prod_fix;
  logic [XLEN-1:0]   mplier, mplier_next, a_mag, b_mag, div_raw, div_fix, special_val;
  logic [XLEN-1:0]   rem_next, final_res;
  logic [XLEN:0]     r_shift;
  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic              res_neg, a_sign, b_sign, special, div_zero, div_ovf, accept, calc_last;

  assign in_ready  = (state == MD_IDLE);
  assign out_valid = (state == MD_DONE);
  assign accept    = in_valid && in_ready;

  // Operand signs: MULH/DIV/REM treat both signed, MULHSU only rs1.
  assign a_sign = rs1_data[XLEN-1] && (funct3 == FUNCT3_MULH || funct3 == FUNCT3_MULHSU ||
                                      funct3 == FUNCT3_DIV  || funct3 == FUNCT3_REM);
  assign b_sign = rs2_data[XLEN-1] && (funct3 == FUNCT3_MULH || funct3 == FUNCT3_DIV ||
                                      funct3 == FUNCT3_REM);

  muldiv_sign_fix #(.W(XLEN)) u_fix_a (.value(rs1_data), .negate(a_sign), .result(a_mag));
  muldiv_sign_fix #(.W(XLEN)) u_fix_b (.value(rs2_data), .negate(b_sign), .result(b_mag));

  assign div_zero = is_div_op(funct3) && (rs2_data == '0);
  assign div_ovf  = (funct3 == FUNCT3_DIV || funct3 == FUNCT3_REM) &&
                    (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign special  = div_zero || div_ovf;

  // funct3[1] picks remainder among the divide ops.
  always_comb begin
    special_val = '0;
    if (div_zero)     special_val = funct3[1] ? rs1_data : '1;
    else if (div_ovf) special_val = funct3[1] ? '0 : rs1_data;
  end

  // One iteration. Divide keeps remainder in acc[2X-1:X] and the dividend /
  // quotient shift register in acc[X-1:0]; multiply accumulates the product.
  assign r_shift = acc[2*XLEN-1:XLEN-1];
  always_comb begin
    rem_next    = '0;
    acc_next    = acc;
    mplier_next = mplier;
    if (is_div_op(op)) begin
      if (r_shift >= {1'b0, mplier}) begin
        rem_next = XLEN'(r_shift - {1'b0, mplier});
        acc_next = {rem_next, acc[XLEN-2:0], 1'b1};
      end else begin
        rem_next = XLEN'(r_shift);
        acc_next = {rem_next, acc[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next    = mplier[0] ? (acc + mcand) : acc;
      mplier_next = mplier >> 1;
    end
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_p (.value(acc_next), .negate(res_neg), .result(prod_fix));

  assign div_raw = op[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
  muldiv_sign_fix #(.W(XLEN)) u_fix_d (.value(div_raw), .negate(res_neg), .result(div_fix));

  assign final_res = is_div_op(op)        ? div_fix :
                     (op == FUNCT3_MUL)   ? prod_fix[XLEN-1:0] :
                                            prod_fix[2*XLEN-1:XLEN];

`ifdef MULDIV_EARLY_OUT_EN
  assign calc_last = (count == CW'(1)) || (!is_div_op(op) && mplier_next == '0);
`else
  assign calc_last = (count == CW'(1));
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (in_valid)  state_next = special ? MD_DONE : MD_CALC;
      MD_CALC: if (calc_last) state_next = MD_DONE;
      MD_DONE: if (out_ready) state_next = MD_IDLE;
      default:                state_next = MD_IDLE;
    endcase
    if (flush) state_next = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      op          <= '0;
      res_neg     <= 1'b0;
      out_data    <= '0;
      out_rd_addr <= '0;
    end else if (!flush) begin
      if (accept) begin
        op          <= funct3;
        out_rd_addr <= rd_addr;
        // Remainder follows the dividend; everything else is sign(a)^sign(b).
        res_neg     <= (funct3 == FUNCT3_REM) ? a_sign : (a_sign ^ b_sign);
        count       <= CW'(XLEN);
        mplier      <= b_mag;
        acc         <= is_div_op(funct3) ? {{XLEN{1'b0}}, a_mag} : '0;
        mcand       <= is_div_op(funct3) ? '0 : {{XLEN{1'b0}}, a_mag};
        if (special) out_data <= special_val;
      end else if (state == MD_CALC) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier_next;
        count  <= count - CW'(1);
        if (calc_last) out_data <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, out_data;
  logic [4:0]  rd_addr, out_rd_addr;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd_addr(out_rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f >= 3'd4 && b == 32'd0) return 1'b1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // Reference result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'd0, a};           ub = {32'd0, b};
    ia = $signed(a);           ib = $signed(b);
    p  = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [31:0] bm;
    int n;
`endif
    if (is_special(f, a, b)) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (f < 3'd4) begin
      bm = (f == 3'd1 && b[31]) ? (32'd0 - b) : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (bm[i]) n = i + 1;
      return 1 + n;
    end
`endif
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold);
    int lat;
    logic [31:0] held;
    chk("idle_ready", in_ready, 1);
    funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat(f, a, b));
    chk("data", out_data, ref_res(f, a, b));
    chk("rd", out_rd_addr, rd);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, held);
      chk("hold_busy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Abort an op mid-CALC with flush (use_rst=0) or rst (use_rst=1).
  task automatic abort_test(input logic use_rst);
    int seen;
    funct3 = 3'd5; rs1_data = 32'h1234_5678; rs2_data = 32'd3; rd_addr = 5'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy", in_ready, 0);
    if (use_rst) rst = 1'b0; else flush = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    chk(use_rst ? "rst_ready" : "flush_ready", in_ready, 1);
    chk(use_rst ? "rst_valid" : "flush_valid", out_valid, 0);
    if (use_rst) begin
      chk("rst_data", out_data, 0);
      chk("rst_rd", out_rd_addr, 0);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk(use_rst ? "rst_noout" : "flush_noout", seen, 0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", in_ready, 1);
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_rd", out_rd_addr, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5'd5, 0);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd6, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0);
    run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd10, 0);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd11, 0);
    run_op(3'd7, 32'd7, 32'hFFFF_FFFE, 5'd12, 0);
    run_op(3'd5, 32'h1234, 32'd0, 5'd13, 0);
    run_op(3'd6, 32'h1234, 32'd0, 5'd14, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
    run_op(3'd1, 32'd100, 32'd7, 5'd16, 5);
    run_op(3'd0, 32'd5, 32'd1, 5'd17, 0);

    abort_test(1'b0);
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd18, 0);
    abort_test(1'b1);
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd19, 0);

    for (int n = 0; n < 150; n++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)),
             $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
